// File: rtl/serial_ram_loader_pkg.sv
// Shared types and constants for the boot-time serial RAM loader.
// Holds the loader state enum and frame field sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W = 16;

  function automatic logic [7:0] chk_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/serial_ram_loader_if.sv
// Byte-stream input and RAM write port of the loader.
// slave = loader view, master = source/RAM side view.
interface serial_ram_loader_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic                  ram_cs;
  logic                  ram_oe;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output ram_addr,
    output ram_wdata,
    output ram_we,
    output ram_cs,
    output ram_oe
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    input  ram_cs,
    input  ram_oe
  );

endinterface

// File: rtl/serial_ram_loader.sv
// Framed byte-stream loader writing an image into system RAM.
// Define LOADER_CHECKSUM_EN to add the trailing checksum byte.
module serial_ram_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_ram_loader_if.slave  bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error
);

  loader_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]            lo_q, lo_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [7:0]            chk_q, chk_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic       rx_ready;
  logic       xfer;
  logic [7:0] rx_byte;
  logic       last_wr;
  logic       len_zero;

  assign rx_ready = (state_q != S_WRITE);
  assign xfer     = bus.rx_valid & rx_ready;
  assign rx_byte  = bus.rx_data;
  assign last_wr  = (len_q == LEN_W'(1));
  assign len_zero = ({rx_byte, lo_q} == '0);

  assign bus.rx_ready  = rx_ready;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = (state_q == S_WRITE);
  assign bus.ram_cs    = (state_q == S_WRITE);
  assign bus.ram_oe    = 1'b0;

  assign cpu_hold = hold_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = err_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      len_q   <= '0;
      chk_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Frame parser: next state, counters, checksum, status
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    len_d   = len_q;
    chk_d   = chk_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (xfer && rx_byte == SYNC_BYTE) begin
          state_d = S_ADDR_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          chk_d   = '0;
        end
      end
      S_ADDR_LO: begin
        if (xfer) begin
          lo_d    = rx_byte;
          chk_d   = chk_add(chk_q, rx_byte);
          state_d = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (xfer) begin
          addr_d  = ADDR_WIDTH'({rx_byte, lo_q});
          chk_d   = chk_add(chk_q, rx_byte);
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          lo_d    = rx_byte;
          chk_d   = chk_add(chk_q, rx_byte);
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = {rx_byte, lo_q};
          chk_d = chk_add(chk_q, rx_byte);
          if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d = DATA_WIDTH'(rx_byte);
          chk_d   = chk_add(chk_q, rx_byte);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        len_d  = len_q - 1'b1;
        if (last_wr) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
          if (chk_add(chk_q, rx_byte) == 8'h00) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`else
        state_d = S_IDLE;
        hold_d  = 1'b0;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_ram_loader.sv
// Directed bench for serial_ram_loader with a RAM-write scoreboard.
// Honours LOADER_CHECKSUM_EN for the trailing checksum byte.
module tb_serial_ram_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold, busy, done, error;

  serial_ram_loader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus ();

  serial_ram_loader #(
    .ADDR_WIDTH(15),
    .DATA_WIDTH(8),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic       prev_we = 1'b0;
  logic [7:0] pl [16];

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: compare every RAM write against the scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (bus.ram_oe !== 1'b0) check("ram_oe", bus.ram_oe, 0);
    if (bus.ram_we === 1'b1) begin
      check("we_pulse", prev_we, 0);
      check("rdy_in_write", bus.rx_ready, 0);
      check("cs_with_we", bus.ram_cs, 1);
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.ram_addr, e.a);
        check("wr_data", bus.ram_wdata, e.d);
      end
    end
    prev_we = bus.ram_we;
  end

  task automatic send(input logic [7:0] b);
    int cyc;
    cyc = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.rx_ready !== 1'b1) check("rdy_timeout", 0, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic frame(
    input logic [15:0] a,
    input int          n,
    input logic        bad
  );
    logic [7:0]  s;
    logic [15:0] nl;
    nl = 16'(n);
    s = a[7:0] + a[15:8] + nl[7:0] + nl[15:8];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(wr_t'({15'(a + 16'(i)), pl[i]}));
      s = s + pl[i];
    end
    send(8'hA5);
    check("hold_sync", cpu_hold, 1);
    check("busy_sync", busy, 1);
    check("err_clr_sync", error, 0);
    send(a[7:0]);
    send(a[15:8]);
    send(nl[7:0]);
    send(nl[15:8]);
    for (int i = 0; i < n; i++) send(pl[i]);
`ifdef LOADER_CHECKSUM_EN
    send(bad ? 8'h00 : 8'h00 - s);
`else
    if (bad) check("bad_chk_needs_macro", 0, 1);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_ready", bus.rx_ready, 1);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    d0 = done_cnt;
    frame(16'h0200, 3, 1'b0);
    check("t1_done", done_cnt - d0, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_busy", busy, 0);

    // leading garbage discarded
    send(8'h00);
    check("t2_busy0", busy, 0);
    send(8'hFF);
    check("t2_busy1", busy, 0);
    check("t2_hold", cpu_hold, 0);
    pl[0] = 8'h44; pl[1] = 8'h55; pl[2] = 8'h66;
    d0 = done_cnt;
    frame(16'h1234, 3, 1'b0);
    check("t2_done", done_cnt - d0, 1);

    // address wrap, high bit of ADDR_HI dropped
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    d0 = done_cnt;
    frame(16'hFFFF, 2, 1'b0);
    check("t3_done", done_cnt - d0, 1);

    // zero length
    d0 = done_cnt;
    frame(16'h0300, 0, 1'b0);
    check("t4_done", done_cnt - d0, 1);
    check("t4_hold", cpu_hold, 0);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum: data kept, error set, no done
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    d0 = done_cnt;
    frame(16'h0200, 3, 1'b1);
    check("t5_nodone", done_cnt - d0, 0);
    check("t5_err", error, 1);
    check("t5_hold", cpu_hold, 0);
    pl[0] = 8'h77;
    d0 = done_cnt;
    frame(16'h0400, 1, 1'b0);
    check("t5_done", done_cnt - d0, 1);
    check("t5_err_clr", error, 0);
`endif

    // reset mid-frame after second payload byte
    exp_q.push_back(wr_t'({15'h0100, 8'h11}));
    exp_q.push_back(wr_t'({15'h0101, 8'h22}));
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h05);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    check("t6_hold_pre", cpu_hold, 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_hold", cpu_hold, 0);
    check("t6_ready", bus.rx_ready, 1);
    check("t6_we", bus.ram_we, 0);
    check("t6_cs", bus.ram_cs, 0);
    check("t6_addr", bus.ram_addr, 0);
    check("t6_wdata", bus.ram_wdata, 0);
    check("t6_done", done, 0);
    check("t6_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    d0 = done_cnt;
    frame(16'h0100, 2, 1'b0);
    check("t6_done_after", done_cnt - d0, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
